// File: rtl/i2s_master.sv
// Clock-master Philips I2S engine: 64-bit frames, 32-bit slots, MSB-first
// left-justified samples, valid/ready tx holding register, one rx pulse per frame.
module i2s_master #(
   parameter int SCLK_DIV = 8,
   parameter int DATA_W   = 24
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] tx_left,
   input  logic [DATA_W-1:0] tx_right,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_left,
   output logic [DATA_W-1:0] rx_right,
   output logic              rx_valid,
   output logic              underrun,
   output logic              i2s_sclk,
   output logic              i2s_lrclk,
   output logic              i2s_dout,
   input  logic              i2s_din
);

   localparam int                DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam logic [5:0]        L_LAST   = 6'(DATA_W);
   localparam logic [5:0]        R_FIRST  = 6'd33;
   localparam logic [5:0]        R_LAST   = 6'(32 + DATA_W);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [5:0]        bit_cnt;
   logic              hold_full;
   logic              rx_pend;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic [DATA_W-1:0] tx_l, tx_r;
   logic [DATA_W-1:0] rx_l, rx_r;

   logic       tick, fall, rise, load, take;
   logic [5:0] bit_nxt;

   function automatic logic in_left(input logic [5:0] b);
      return (b != 6'd0) && (b <= L_LAST);
   endfunction

   function automatic logic in_right(input logic [5:0] b);
      return (b >= R_FIRST) && (b <= R_LAST);
   endfunction

   assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
   assign fall     = tick & i2s_sclk;
   assign rise     = tick & ~i2s_sclk;
   assign bit_nxt  = bit_cnt + 6'd1;
   assign load     = fall && (bit_cnt == 6'd63);
   assign take     = tx_valid & ~hold_full;
   assign tx_ready = ~hold_full;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= 6'd63;
         i2s_sclk  <= 1'b1;
         i2s_lrclk <= 1'b1;
         i2s_dout  <= 1'b0;
         hold_full <= 1'b0;
         rx_pend   <= 1'b0;
         rx_valid  <= 1'b0;
         underrun  <= 1'b0;
         rx_left   <= '0;
         rx_right  <= '0;
      end else begin
         rx_valid <= rx_pend;
         rx_pend  <= 1'b0;
         underrun <= 1'b0;

         case (state)
            IDLE:     if (enable) state <= RUN;
            RUN:      if (!enable) state <= STOPPING;
            STOPPING: begin
               if (enable)
                  state <= RUN;
               else if (rise && bit_cnt == 6'd63)
                  state <= IDLE;
            end
            default:  state <= IDLE;
         endcase

         if (state != IDLE)
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick)
            i2s_sclk <= ~i2s_sclk;

         // fall event: advance bit, drive lrclk/dout for the new bit
         if (fall) begin
            bit_cnt   <= bit_nxt;
            i2s_lrclk <= bit_nxt[5];
            if (in_left(bit_nxt))
               i2s_dout <= tx_l[DATA_W-1];
            else if (in_right(bit_nxt))
               i2s_dout <= tx_r[DATA_W-1];
            else
               i2s_dout <= 1'b0;
         end

         // last right bit captured on this rise; present it next cycle
         if (rise && bit_cnt == R_LAST)
            rx_pend <= 1'b1;
         if (rx_pend) begin
            rx_left  <= rx_l;
            rx_right <= rx_r;
         end

         if (load && hold_full)
            hold_full <= 1'b0;
         else if (take)
            hold_full <= 1'b1;
         if (load && !hold_full)
            underrun <= 1'b1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (take) begin
         hold_l <= tx_left;
         hold_r <= tx_right;
      end
      if (load) begin
         tx_l <= hold_full ? hold_l : '0;
         tx_r <= hold_full ? hold_r : '0;
      end else if (fall && in_left(bit_nxt)) begin
         tx_l <= tx_l << 1;
      end else if (fall && in_right(bit_nxt)) begin
         tx_r <= tx_r << 1;
      end
      if (rise && in_left(bit_cnt))
         rx_l <= {rx_l[DATA_W-2:0], i2s_din};
      if (rise && in_right(bit_cnt))
         rx_r <= {rx_r[DATA_W-2:0], i2s_din};
   end

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master in loopback: frame table plus hand sequences
// for back-to-back offers, stop/restart and mid-frame reset.
module tb_i2s_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        tx_valid = 1'b0;
   logic [23:0] tx_left = '0, tx_right = '0;
   logic        tx_ready, rx_valid, underrun, sclk, lrclk, dout, din;
   logic [23:0] rx_left, rx_right;

   assign din = dout;

   i2s_master dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
      .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .underrun(underrun),
      .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_dout(dout), .i2s_din(din)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int tb_bit = 63, fall_total = 0, rxv_cnt = 0, ur_cnt = 0;
   int exp_rxv = 0, exp_ur = 0, n = 0, snap = 0;
   logic prev_sclk = 1'b1, fell = 1'b0;
   logic [63:0] dvec = '0, lvec = '0;
   logic [23:0] cap_l = '0, cap_r = '0;

   localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

   typedef struct {
      logic        valid;
      logic [23:0] l, r;
      logic [23:0] exp_rl, exp_rr;
      logic        exp_ur;
   } frame_t;
   frame_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clk cycle, sampled on the falling clk edge; tracks sclk edges and pulses.
   task automatic step();
      @(negedge clk);
      if (rx_valid) begin
         rxv_cnt++;
         cap_l = rx_left;
         cap_r = rx_right;
      end
      if (underrun) ur_cnt++;
      fell = prev_sclk && !sclk;
      if (fell) begin
         fall_total++;
         tb_bit = (tb_bit + 1) % 64;
         dvec[tb_bit] = dout;
         lvec[tb_bit] = lrclk;
      end
      prev_sclk = sclk;
   endtask

   task automatic wait_fall_to(input int b);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!(fell && tb_bit == b) && k < 2000);
      if (k >= 2000) begin
         tests++;
         fails++;
         $display("FAIL wait_bit_%0d: no sclk fall into that bit within %0d clks", b, k);
      end
   endtask

   function automatic logic [63:0] exp_dvec(input logic [23:0] l, input logic [23:0] r);
      logic [63:0] v;
      v = '0;
      for (int k = 1; k <= 24; k++) v[k] = l[24-k];
      for (int k = 33; k <= 56; k++) v[k] = r[56-k];
      return v;
   endfunction

   task automatic offer(input string name, input logic [23:0] l, input logic [23:0] r);
      tx_left  = l;
      tx_right = r;
      tx_valid = 1'b1;
      check({name, "_ready_before"}, 64'(tx_ready), 64'(1'b1));
      step();
      tx_valid = 1'b0;
      check({name, "_ready_after"}, 64'(tx_ready), 64'(1'b0));
   endtask

   task automatic check_reset(input string name);
      check({name, "_sclk"},     64'(sclk),     64'(1'b1));
      check({name, "_lrclk"},    64'(lrclk),    64'(1'b1));
      check({name, "_dout"},     64'(dout),     64'(1'b0));
      check({name, "_tx_ready"}, 64'(tx_ready), 64'(1'b1));
      check({name, "_rx_valid"}, 64'(rx_valid), 64'(1'b0));
      check({name, "_underrun"}, 64'(underrun), 64'(1'b0));
      check({name, "_rx_left"},  64'(rx_left),  64'(24'h0));
      check({name, "_rx_right"}, 64'(rx_right), 64'(24'h0));
   endtask

   task automatic check_frame(input string name, input logic [23:0] l, input logic [23:0] r);
      check({name, "_dout"},  dvec, exp_dvec(l, r));
      check({name, "_lrclk"}, lvec, LR_EXP);
      check({name, "_rxcnt"}, 64'(rxv_cnt), 64'(exp_rxv));
      check({name, "_urcnt"}, 64'(ur_cnt), 64'(exp_ur));
      check({name, "_rx"},    {16'h0, cap_l, cap_r}, {16'h0, l, r});
   endtask

   initial begin
      tbl[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 1'b0};
      tbl[1] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 1'b0};
      tbl[2] = '{1'b0, 24'h123456, 24'h654321, 24'h000000, 24'h000000, 1'b1};
      tbl[3] = '{1'b0, 24'h111111, 24'h222222, 24'h000000, 24'h000000, 1'b1};
      tbl[4] = '{1'b0, 24'h333333, 24'h444444, 24'h000000, 24'h000000, 1'b1};
      tbl[5] = '{1'b1, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001, 1'b0};

      step();
      step();
      check_reset("reset0");
      rst_n = 1'b1;
      step();
      check_reset("idle0");

      // Preload frame 0 while idle, then enable: first fall 8 clks after enable is seen.
      offer("pre", tbl[0].l, tbl[0].r);
      enable = 1'b1;
      step();
      n = 0;
      do begin step(); n++; end while (!fell && n < 100);
      check("first_fall_delay", 64'(n), 64'(8));
      check("first_fall_lrclk", 64'(lrclk), 64'(1'b0));
      n = 0;
      do begin step(); n++; end while (!fell && n < 100);
      check("sclk_period", 64'(n), 64'(16));

      for (int k = 0; k < 6; k++) begin
         wait_fall_to(5);
         if (k < 5 && tbl[k+1].valid) offer($sformatf("tbl%0d", k + 1), tbl[k+1].l, tbl[k+1].r);
         wait_fall_to(63);
         exp_rxv++;
         if (tbl[k].exp_ur) exp_ur++;
         check_frame($sformatf("frame%0d", k), tbl[k].exp_rl, tbl[k].exp_rr);
      end

      // Back-to-back: second sample waits in the bus until the next bit-0 load.
      wait_fall_to(5);
      exp_ur++;
      tx_left = 24'hC0FFEE; tx_right = 24'h0BADF0; tx_valid = 1'b1;
      check("b2b_ready_first", 64'(tx_ready), 64'(1'b1));
      step();
      tx_left = 24'h13579B; tx_right = 24'h2468AC;
      check("b2b_ready_held", 64'(tx_ready), 64'(1'b0));
      n = 0;
      while (!tx_ready && n < 2000) begin step(); n++; end
      check("b2b_ready_at_load", {57'h0, fell, tb_bit[5:0]}, {57'h0, 1'b1, 6'd0});
      step();
      tx_valid = 1'b0;
      check("b2b_second_taken", 64'(tx_ready), 64'(1'b0));
      wait_fall_to(63);
      exp_rxv += 2;
      check_frame("b2b_first", 24'hC0FFEE, 24'h0BADF0);
      wait_fall_to(63);
      exp_rxv++;
      check_frame("b2b_second", 24'h13579B, 24'h2468AC);

      // Stop at bit 10: frame completes, rx pulse fires, then idle with sclk high.
      wait_fall_to(5);
      exp_ur++;
      offer("stop", 24'h5EED01, 24'hABCDEF);
      wait_fall_to(63);
      exp_rxv++;
      wait_fall_to(10);
      enable = 1'b0;
      wait_fall_to(63);
      exp_rxv++;
      check_frame("stop_frame", 24'h5EED01, 24'hABCDEF);
      snap = fall_total;
      repeat (48) step();
      check("stop_no_falls", 64'(fall_total), 64'(snap));
      check("stop_idle_pins", {61'h0, sclk, lrclk, dout}, {61'h0, 1'b1, 1'b1, 1'b0});
      check("stop_rxcnt", 64'(rxv_cnt), 64'(exp_rxv));

      // Restart begins at bit 0: the empty holding register underruns on that load.
      enable = 1'b1;
      step();
      n = 0;
      do begin step(); n++; end while (!fell && n < 100);
      exp_ur++;
      check("restart_delay", 64'(n), 64'(8));
      check("restart_lrclk", 64'(lrclk), 64'(1'b0));
      check("restart_urcnt", 64'(ur_cnt), 64'(exp_ur));

      // Mid-frame reset discards the held sample and the partial frame.
      wait_fall_to(5);
      offer("mid", 24'h777777, 24'h888888);
      wait_fall_to(20);
      rst_n = 1'b0;
      step();
      check_reset("reset_mid");
      step();
      rst_n = 1'b1;
      tb_bit = 63;
      wait_fall_to(63);
      exp_rxv++;
      exp_ur++;
      check_frame("after_reset", 24'h000000, 24'h000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d failed so far", fails);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/i2s_master.md
# i2s_master

Clock-master I2S engine for the FPGAAudio SoC: generates `i2s_sclk`/`i2s_lrclk` from the system clock, serializes 24-bit stereo samples onto `i2s_dout`, and deserializes `i2s_din`. It is the driving end for any I2S slave port, such as the SoC's `i2s_*` conduit, in loopback and bench setups. Samples enter through a valid/ready holding register and leave as one `rx_valid` pulse per frame. Format is Philips I2S with 32-bit slots and MSB-first, left-justified 24-bit data.

## Interface

- `SCLK_DIV`, 8: clk cycles per sclk half-period; must be ≥2. The default gives 3.125 MHz sclk and 48.83 kHz fs at 50 MHz.
- `DATA_W`, 24: sample width; must be ≤31.
- `clk_clk` in 1: system clock, the only clock.
- `reset_reset_n` in 1: synchronous reset, active low.
- `enable` in 1: run request.
- `tx_left`, `tx_right` in DATA_W: sample to transmit.
- `tx_valid` in 1: sample offered.
- `tx_ready` out 1: holding register empty.
- `rx_left`, `rx_right` out DATA_W: last received sample.
- `rx_valid` out 1: 1-cycle pulse when a new rx sample is presented.
- `underrun` out 1: 1-cycle pulse when a frame is loaded with no sample.
- `i2s_sclk` out 1: bit clock.
- `i2s_lrclk` out 1: word select; 0 = left.
- `i2s_dout` out 1: serial data out.
- `i2s_din` in 1: serial data in.

## Operation

- Reset values:
  - `i2s_sclk`=1, `i2s_lrclk`=1, `i2s_dout`=0
  - `tx_ready`=1, `rx_valid`=0, `underrun`=0, `rx_left`/`rx_right`=0
  - bit_cnt=63, div_cnt=0, holding register empty, state IDLE
- States:
  - IDLE: divider held, outputs static. Goes to RUN when `enable`=1.
  - RUN: clocks running. Goes to STOPPING when `enable`=0.
  - STOPPING: clocks running. Goes back to RUN if `enable` returns to 1. Goes to IDLE on the rise event that ends bit 63, leaving sclk=1.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1 while in RUN or STOPPING.
  - At terminal count, sclk toggles and div_cnt returns to 0.
  - A toggle 1→0 is a fall event; a toggle 0→1 is a rise event.
- Bit counter and outputs, updated on fall events:
  - bit_cnt increments mod 64.
  - `i2s_lrclk` = 0 for bit_cnt 0..31 and 1 for 32..63.
  - `i2s_dout`, registered:
    - bit_cnt 1..DATA_W: left, MSB first.
    - bit_cnt 33..32+DATA_W: right, MSB first.
    - All other bits: 0.
  - MSB therefore lags each lrclk edge by one sclk, per Philips format.
- Frame load, on the fall event into bit_cnt 0:
  - Holding register full: copy it to the tx shift registers and mark it empty.
  - Holding register empty: load zeros and pulse `underrun`.
- Holding register:
  - `tx_ready` = holding register empty.
  - A transfer occurs on `tx_valid`&`tx_ready` at a clk edge.
  - A transfer in the same cycle as a frame load with an empty register counts as underrun. The new sample stays in the register for the next frame.
  - `tx_valid` while `tx_ready`=0 is held off with no loss. The sender must hold the data stable.
- Receive:
  - `i2s_din` is sampled on rise events.
  - bit_cnt 1..DATA_W fill the left shift register; 33..32+DATA_W fill the right, MSB first.
  - On the cycle after the rise event of bit 32+DATA_W, `rx_left`/`rx_right` update and `rx_valid` pulses for 1 cycle.
  - Outputs hold until the next frame.
  - Padding bits on `i2s_din` are ignored.
- Reset at any time returns to the reset values. An in-flight frame, the held sample, and partial rx data are discarded, and no `rx_valid` is produced.

## Timing

- sclk period = 2·SCLK_DIV clk cycles. A frame is 64 sclk periods = 128·SCLK_DIV clk cycles (1024 at default).
- First fall event comes SCLK_DIV cycles after `enable` is seen high in IDLE.
- `i2s_dout`/`i2s_lrclk` change on the same clk edge as the sclk fall. The external slave samples half a bit later.
- tx latency: a sample accepted before the load of frame N has its left MSB on `i2s_dout` during bit 1 of frame N.
- Loopback (`i2s_din`=`i2s_dout`): the frame-N sample appears on `rx_*` in frame N, 1 clk after the rise event of bit 56 at default.
- STOPPING always completes the current frame, including its rx pulse; there are no partial frames.

## Test plan

- Reset, then `enable`=1 → outputs at reset values; first sclk fall 8 clks later; lrclk falls with bit 0; sclk period 16 clks.
- Send L=0xA5A5A5, R=0x5A5A5A, check each bit → dout shows 1010… from bit 1 and 0101… from bit 33; bits 0, 25–32 and 57–63 are 0; lrclk edges one bit before each MSB.
- Loopback `i2s_din`=`i2s_dout`, L=0x800001, R=0x7FFFFE → one `rx_valid` pulse per frame with identical values; no pulse in the first partial frame.
- No `tx_valid` for 3 frames → dout all zeros, exactly one `underrun` pulse per frame, at bit 0 load.
- Offer two samples back-to-back → first accepted immediately; `tx_ready` low until the next bit-0 load; second accepted then and transmitted in the following frame; no loss or duplication.
- Drop `enable` at bit 10 → frame completes, rx pulse still fires, idle with sclk=1, lrclk=1, bit_cnt=63. Re-enable → resumes at bit 0. Assert reset mid-frame → all outputs at reset values on the next clk.
